// File: rtl/rem5_sched.sv
// Two-requester front end for a serial mod-DIV remainder engine.
// Each granted word is shifted in MSB-first and the result is held on a valid/ready port.
module rem5_sched #(
  parameter int WIDTH = 8,
  parameter int DIV   = 5,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [RW-1:0]    out_rem,
  output logic             out_div,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [RW:0] DIV_W = (RW + 1)'(DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requester ready is combinational, depends on valid, and is only ever high in IDLE.
  // The result port holds out_* stable while out_valid is high until out_ready is seen.

  state_t           state;
  logic             rr;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rem;
  logic             id;

  logic             gnt0;
  logic             gnt1;
  logic             take;
  logic             last_shift;
  logic [RW:0]      t;
  logic [RW:0]      t_sub;
  logic [RW-1:0]    rem_next;

  // rr = 1 prefers requester 1 when both are asking.
  assign gnt0 = in0_valid & (~in1_valid | ~rr);
  assign gnt1 = in1_valid & (~in0_valid | rr);

  assign in0_ready = (state == IDLE) & gnt0;
  assign in1_ready = (state == IDLE) & gnt1;
  assign take      = in0_ready | in1_ready;
  assign busy      = (state != IDLE);

  assign last_shift = (cnt == CW'(WIDTH - 1));

  // rem < DIV, so t < 2*DIV and one conditional subtract keeps it reduced.
  always_comb begin
    t        = {rem, sreg[WIDTH-1]};
    t_sub    = t - DIV_W;
    rem_next = t[RW-1:0];
    if (t >= DIV_W) begin
      rem_next = t_sub[RW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
      rem       <= '0;
      id        <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_rem   <= '0;
      out_div   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            sreg  <= in1_ready ? in1_data : in0_data;
            rem   <= '0;
            cnt   <= '0;
            id    <= in1_ready;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          rem  <= rem_next;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          if (last_shift) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_rem   <= rem_next;
            out_div   <= (rem_next == '0);
            out_id    <= id;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rr        <= ~out_id;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rem5_sched.sv
// Randomized and directed bench for rem5_sched with a queue-based scoreboard
// and a rule-level model of arbitration, latency and remainders.
module tb_rem5_sched;

  localparam int WIDTH = 8;
  localparam int DIV   = 5;
  localparam int RW    = 3;
  localparam int EW    = RW + 2;

  logic             clk;
  logic             rst;
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [RW-1:0]    out_rem;
  logic             out_div;
  logic             busy;

  rem5_sched #(.WIDTH(WIDTH), .DIV(DIV), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_rem   (out_rem),
    .out_div   (out_div),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard + model
  logic [EW-1:0] exp_q[$];
  bit  m_busy = 1'b0;
  bit  m_rr   = 1'b0;
  bit  waiting = 1'b0;
  int  lat = 0;
  int  cyc = 0;
  int  acc_cnt = 0;
  int  last_acc_cyc = 0;
  int  acc_gap = 0;

  function automatic logic [EW-1:0] model(input bit rid, input logic [WIDTH-1:0] d);
    int r;
    r = int'(d) % DIV;
    return {rid, RW'(r), (r == 0)};
  endfunction

  always @(negedge clk) begin
    bit e0, e1;
    logic [EW-1:0] head;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_busy  = 1'b0;
      m_rr    = 1'b0;
      waiting = 1'b0;
      chk("reset_outputs", {out_valid, out_id, out_rem, out_div, busy}, '0);
    end else begin
      e0 = !m_busy && in0_valid && (!in1_valid || !m_rr);
      e1 = !m_busy && in1_valid && (!in0_valid || m_rr);
      chk("ready", {in0_ready, in1_ready}, {e0, e1});
      chk("busy", busy, m_busy);
      if (waiting) lat++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 1'b0);
        end else begin
          head = exp_q[0];
          chk("result_id_rem_div", {out_id, out_rem, out_div}, head);
          if (waiting) begin
            chk("latency", lat, WIDTH + 1);
            waiting = 1'b0;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            m_rr   = ~head[EW-1];
          end
        end
      end
      if ((in0_valid && in0_ready) || (in1_valid && in1_ready)) begin
        if (in1_valid && in1_ready) exp_q.push_back(model(1'b1, in1_data));
        else                        exp_q.push_back(model(1'b0, in0_data));
        m_busy  = 1'b1;
        waiting = 1'b1;
        lat     = 0;
        acc_cnt++;
        acc_gap = cyc - last_acc_cyc;
        last_acc_cyc = cyc;
      end
    end
  end

  // driver tasks (called from posedge+#1)
  task automatic send(input bit rid, input logic [WIDTH-1:0] d);
    bit acc;
    acc = 1'b0;
    if (rid) begin in1_valid = 1'b1; in1_data = d; end
    else     begin in0_valid = 1'b1; in0_data = d; end
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = rid ? in1_ready : in0_ready;
      @(posedge clk); #1;
    end
    if (rid) in1_valid = 1'b0; else in0_valid = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy && !out_valid;
      @(posedge clk); #1;
    end
    chk("drain", done, 1'b1);
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // single requesters
    send(1'b0, 8'd25); drain();
    send(1'b1, 8'd23); drain();

    // both valid continuously: alternating grants
    in0_data = 8'd10; in1_data = 8'd7;
    in0_valid = 1'b1; in1_valid = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt < base + 4; i++) @(posedge clk);
    #1 in0_valid = 1'b0; in1_valid = 1'b0;
    chk("alternate_count", acc_cnt - base, 4);
    chk("throughput_gap", acc_gap, WIDTH + 2);
    drain();

    // backpressure
    out_ready = 1'b0;
    send(1'b0, 8'd17);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_out_valid", seen, 1'b1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // reset during SHIFT aborts the operation
    send(1'b1, 8'd99);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(1'b0, 8'd254); drain();

    // boundary words
    send(1'b0, 8'd0);   drain();
    send(1'b1, 8'd255); drain();
    send(1'b0, 8'd1);   drain();

    // randomized traffic with random backpressure and dropped valids
    for (int i = 0; i < 600; i++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_data  = WIDTH'($urandom_range(0, 255));
      in1_data  = WIDTH'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
